// File: rtl/recorder_controller_if.sv
// Voice recorder control bus: button pulses, sample strobe,
// sample-memory strobes/address and status flags.
interface recorder_controller_if #(
    parameter int ADDR_W = 16
);
    logic              rec_pulse;
    logic              play_pulse;
    logic              stop_pulse;
    logic              sample_tick;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic              mem_re;
    logic              recording;
    logic              playing;
    logic [ADDR_W:0]   rec_len;
    logic              done;

    modport master (
        input  rec_pulse, play_pulse, stop_pulse, sample_tick,
        output mem_addr, mem_we, mem_re, recording, playing,
        output rec_len, done
    );

    modport slave (
        output rec_pulse, play_pulse, stop_pulse, sample_tick,
        input  mem_addr, mem_we, mem_re, recording, playing,
        input  rec_len, done
    );
endinterface

// File: rtl/recorder_controller.sv
// Record/playback sequencer: turns button pulses and sample ticks
// into sample-memory address and write/read strobes.
module recorder_controller #(
    parameter int ADDR_W   = 16,
    parameter int MAX_ADDR = 2**ADDR_W - 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    recorder_controller_if.master  bus
);
    typedef enum logic [1:0] {IDLE, REC, PLAY} state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(MAX_ADDR);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic              we_q, we_d;
    logic              re_q, re_d;
    logic              done_q, done_d;
    logic              btn;
    logic              tick_ok;

    // Any button press this cycle swallows a coincident tick.
    assign btn     = bus.rec_pulse | bus.play_pulse | bus.stop_pulse;
    assign tick_ok = bus.sample_tick & ~btn;

    // Next state: a strobe issued last cycle always retires first,
    // then buttons (stop > rec > play) and ticks are applied.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        we_d    = 1'b0;
        re_d    = 1'b0;
        done_d  = 1'b0;
        if (we_q || re_q) begin
            addr_d = addr_q + 1'b1;
        end
        if (we_q) begin
            len_d = len_q + 1'b1;
        end
        if (bus.stop_pulse) begin
            state_d = IDLE;
            addr_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.rec_pulse) begin
                        state_d = REC;
                        addr_d  = '0;
                        len_d   = '0;
                    end else if (bus.play_pulse && len_q != '0) begin
                        state_d = PLAY;
                        addr_d  = '0;
                    end
                end
                REC: begin
                    if (done_q) begin
                        state_d = IDLE;
                        addr_d  = '0;
                    end else if (tick_ok) begin
                        we_d   = 1'b1;
                        done_d = (addr_d == LAST);
                    end
                end
                PLAY: begin
                    if (bus.rec_pulse) begin
                        state_d = REC;
                        addr_d  = '0;
                        len_d   = '0;
                    end else if (done_q) begin
                        state_d = IDLE;
                        addr_d  = '0;
                    end else if (tick_ok) begin
                        re_d   = 1'b1;
                        done_d = ({1'b0, addr_d} == len_q - 1'b1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    addr_d  = '0;
                end
            endcase
        end
    end

    // State and output registers; reset drops any take in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            we_q    <= we_d;
            re_q    <= re_d;
            done_q  <= done_d;
        end
    end

    assign bus.mem_addr  = addr_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_re    = re_q;
    assign bus.rec_len   = len_q;
    assign bus.done      = done_q;
    assign bus.recording = (state_q == REC);
    assign bus.playing   = (state_q == PLAY);
endmodule

// File: tb/tb_recorder_controller.sv
// Self-checking bench for recorder_controller (ADDR_W=3):
// vector table, directed corner sequences, random vs model.
module tb_recorder_controller;
    localparam int AW   = 3;
    localparam int MAXA = 7;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    recorder_controller_if #(.ADDR_W(AW)) bus ();

    recorder_controller #(.ADDR_W(AW), .MAX_ADDR(MAXA)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: mode 0 idle, 1 record, 2 play.
    int m_mode, m_addr, m_len;
    bit m_we, m_re, m_done;

    typedef struct {
        bit r, p, s, t;
        bit we, re, rc, pl, dn;
        int len, addr;
    } vec_t;

    function automatic logic [11:0] mk(bit we, bit re, bit rc, bit pl,
                                       bit dn, int len, int addr);
        return {we, re, rc, pl, dn, 4'(len), 3'(addr)};
    endfunction

    function automatic logic [11:0] dut_out();
        return {bus.mem_we, bus.mem_re, bus.recording, bus.playing,
                bus.done, bus.rec_len, bus.mem_addr};
    endfunction

    function automatic logic [11:0] model_out();
        return mk(m_we, m_re, m_mode == 1, m_mode == 2, m_done,
                  m_len, m_addr);
    endfunction

    task automatic check(string name, logic [11:0] exp);
        tests++;
        if (dut_out() !== exp) begin
            fails++;
            $display("FAIL %s: got we/re/rec/play/done/len/addr=%b want %b",
                     name, dut_out(), exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_addr = 0; m_len = 0;
        m_we = 0; m_re = 0; m_done = 0;
    endtask

    // One clock edge of the specified behaviour.
    task automatic model_edge(bit r, bit p, bit s, bit t);
        bit t_ok;
        bit last;
        t_ok = t && !(r || p || s);
        last = m_done;
        if (m_we) begin
            m_len++;
            m_addr++;
        end
        if (m_re) m_addr++;
        m_we = 0; m_re = 0; m_done = 0;
        if (s) begin
            m_mode = 0;
            m_addr = 0;
        end else if (m_mode == 0) begin
            if (r) begin
                m_mode = 1; m_addr = 0; m_len = 0;
            end else if (p && m_len > 0) begin
                m_mode = 2; m_addr = 0;
            end
        end else if (m_mode == 1) begin
            if (last) begin
                m_mode = 0; m_addr = 0;
            end else if (t_ok) begin
                m_we = 1;
                m_done = (m_addr == MAXA);
            end
        end else begin
            if (r) begin
                m_mode = 1; m_addr = 0; m_len = 0;
            end else if (last) begin
                m_mode = 0; m_addr = 0;
            end else if (t_ok) begin
                m_re = 1;
                m_done = (m_addr == m_len - 1);
            end
        end
    endtask

    task automatic step(bit r, bit p, bit s, bit t);
        bus.rec_pulse   = r;
        bus.play_pulse  = p;
        bus.stop_pulse  = s;
        bus.sample_tick = t;
        model_edge(r, p, s, t);
        @(posedge clk);
        #1;
        bus.rec_pulse   = 1'b0;
        bus.play_pulse  = 1'b0;
        bus.stop_pulse  = 1'b0;
        bus.sample_tick = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.rec_pulse   = 1'b0;
        bus.play_pulse  = 1'b0;
        bus.stop_pulse  = 1'b0;
        bus.sample_tick = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    vec_t tbl[$];

    initial begin
        // rec, 3 ticks, stop; then play, 5 ticks
        tbl.push_back('{1,0,0,0, 0,0,1,0,0, 0,0});
        tbl.push_back('{0,0,0,1, 1,0,1,0,0, 0,0});
        tbl.push_back('{0,0,0,0, 0,0,1,0,0, 1,1});
        tbl.push_back('{0,0,0,1, 1,0,1,0,0, 1,1});
        tbl.push_back('{0,0,0,0, 0,0,1,0,0, 2,2});
        tbl.push_back('{0,0,0,1, 1,0,1,0,0, 2,2});
        tbl.push_back('{0,0,0,0, 0,0,1,0,0, 3,3});
        tbl.push_back('{0,0,1,0, 0,0,0,0,0, 3,0});
        tbl.push_back('{0,1,0,0, 0,0,0,1,0, 3,0});
        tbl.push_back('{0,0,0,1, 0,1,0,1,0, 3,0});
        tbl.push_back('{0,0,0,0, 0,0,0,1,0, 3,1});
        tbl.push_back('{0,0,0,1, 0,1,0,1,0, 3,1});
        tbl.push_back('{0,0,0,0, 0,0,0,1,0, 3,2});
        tbl.push_back('{0,0,0,1, 0,1,0,1,1, 3,2});
        tbl.push_back('{0,0,0,0, 0,0,0,0,0, 3,0});
        tbl.push_back('{0,0,0,1, 0,0,0,0,0, 3,0});
        tbl.push_back('{0,0,0,1, 0,0,0,0,0, 3,0});

        do_reset();
        check("reset", mk(0,0,0,0,0,0,0));
        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].p, tbl[i].s, tbl[i].t);
            check($sformatf("table[%0d]", i),
                  mk(tbl[i].we, tbl[i].re, tbl[i].rc, tbl[i].pl,
                     tbl[i].dn, tbl[i].len, tbl[i].addr));
        end

        // full memory auto-stop
        do_reset();
        step(1,0,0,0);
        for (int i = 0; i < 8; i++) begin
            step(0,0,0,1);
            check($sformatf("fill_we%0d", i), mk(1,0,1,0,i==7,i,i));
            step(0,0,0,0);
            if (i < 7)
                check($sformatf("fill_adv%0d", i), mk(0,0,1,0,0,i+1,i+1));
            else
                check("fill_idle", mk(0,0,0,0,0,8,0));
        end
        step(0,0,0,1);
        check("fill_9th_tick", mk(0,0,0,0,0,8,0));

        // play with empty memory; all buttons at once
        do_reset();
        step(0,1,0,0);
        check("play_empty", mk(0,0,0,0,0,0,0));
        step(1,1,1,0);
        check("all_buttons", mk(0,0,0,0,0,0,0));

        // rec during playback with coincident tick
        do_reset();
        step(1,0,0,0);
        for (int i = 0; i < 3; i++) begin
            step(0,0,0,1);
            step(0,0,0,0);
        end
        step(0,0,1,0);
        step(0,1,0,0);
        step(0,0,0,1);
        step(0,0,0,0);
        check("play_at1", mk(0,0,0,1,0,3,1));
        step(1,0,0,1);
        check("rec_abort", mk(0,0,1,0,0,0,0));
        step(0,0,0,1);
        check("rec_after_abort", mk(1,0,1,0,0,0,0));

        // async reset mid-record
        do_reset();
        step(1,0,0,0);
        for (int i = 0; i < 5; i++) begin
            step(0,0,0,1);
            step(0,0,0,0);
        end
        check("rec_at5", mk(0,0,1,0,0,5,5));
        #2 rst_n = 1'b0;
        #1 check("async_reset", mk(0,0,0,0,0,0,0));
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        step(0,0,0,0);
        check("after_release", mk(0,0,0,0,0,0,0));

        // random traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 24) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 39) == 0, $urandom_range(0, 2) == 0);
            check($sformatf("random[%0d]", i), model_out());
            if (bus.mem_we && bus.mem_re) begin
                tests++;
                fails++;
                $display("FAIL strobe_excl[%0d]: got we=1 re=1 want not both", i);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
